// File: rtl/restoring_divider_pkg.sv
// Shared definitions for the restoring divider: FSM state encoding and
// iteration-counter sizing.
package restoring_divider_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_DONE = 2'b10
    } div_state_e;

    localparam int unsigned STATE_W = 2;

    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/restoring_divider_subtractor.sv
// Unsigned N-bit subtractor: diff = a - b, with bout set when b > a.
module subtractor #(
    parameter int N = 9
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] diff,
    output logic         bout
);

    logic [N:0] full_s;

    assign full_s = {1'b0, a} - {1'b0, b};
    assign diff   = full_s[N-1:0];
    assign bout   = full_s[N];

endmodule

// File: rtl/restoring_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock, with a
// start/done handshake and divide-by-zero flagging.
module restoring_divider
    import restoring_divider_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         ready,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero
);

    localparam int CW = int'(cnt_width(N));

    div_state_e    state_q, state_d;
    logic [N-1:0]  divisor_q, divisor_d;
    logic [N:0]    r_q, r_d;
    logic [N-1:0]  q_q, q_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          dbz_q, dbz_d;
    logic          done_q, done_d;
    logic          busy_q, busy_d;

    logic [N:0]    s_s;
    logic [N:0]    t_s;
    logic          bout_s;
    logic          unused_r_msb_s;

    // Trial dividend: partial remainder shifted left with the next dividend bit.
    assign s_s = {r_q[N-1:0], q_q[N-1]};

    subtractor #(
        .N (N + 1)
    ) u_sub (
        .a    (s_s),
        .b    ({1'b0, divisor_q}),
        .diff (t_s),
        .bout (bout_s)
    );

    // Next-state, datapath and output-flag logic.
    always_comb begin
        state_d   = state_q;
        divisor_d = divisor_q;
        r_d       = r_q;
        q_d       = q_q;
        cnt_d     = cnt_q;
        dbz_d     = dbz_q;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    divisor_d = divisor;
                    cnt_d     = '0;
                    dbz_d     = 1'b0;
                    if (divisor == '0) begin
                        // Zero divisor resolves on the accepting edge.
                        q_d     = '1;
                        r_d     = {1'b0, dividend};
                        dbz_d   = 1'b1;
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        q_d     = dividend;
                        r_d     = '0;
                        state_d = ST_CALC;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (!bout_s) begin
                    r_d = t_s;
                    q_d = {q_q[N-2:0], 1'b1};
                end else begin
                    r_d = s_s;
                    q_d = {q_q[N-2:0], 1'b0};
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_CALC;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d == ST_CALC);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            divisor_q <= '0;
            r_q       <= '0;
            q_q       <= '0;
            cnt_q     <= '0;
            dbz_q     <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            divisor_q <= divisor_d;
            r_q       <= r_d;
            q_q       <= q_d;
            cnt_q     <= cnt_d;
            dbz_q     <= dbz_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    // R never exceeds divisor-1, so its top bit is always 0 once an iteration completes.
    assign unused_r_msb_s = r_q[N];

    assign quotient    = q_q;
    assign remainder   = r_q[N-1:0];
    assign div_by_zero = dbz_q;
    assign done        = done_q;
    assign busy        = busy_q;
    assign ready       = ~busy_q;

endmodule
